// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder for the RV32I fetch stage
//
// Accepts word-aligned fetch requests, waits WAIT_STATES cycles, then presents
// the fetched word with inst_mem_is_valid, holding it while stall is high.
// A separate program-load port writes the array at any time.
//
// Ports:
//   clk                 clock, all state updates on its rising edge
//   reset               asynchronous active-low reset
//   inst_mem_req        fetch request, taken when inst_mem_ready is high
//   inst_mem_address    byte address of the fetch
//   inst_mem_ready      responder can accept a request this cycle
//   inst_mem_is_valid   inst_mem_read_data holds a completed fetch
//   inst_mem_read_data  fetched instruction word
//   inst_mem_err        current response is faulting (misaligned / out of range)
//   stall               consumer stall, holds a valid response
//   prog_we             program-load write strobe
//   prog_addr           program-load word index
//   prog_wdata          program-load word
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_mem_req,
  input  logic [31:0]   inst_mem_address,
  output logic          inst_mem_ready,
  output logic          inst_mem_is_valid,
  output logic [31:0]   inst_mem_read_data,
  output logic          inst_mem_err,
  input  logic          stall,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_wdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [AW-1:0] lat_idx;
  logic          lat_fault;
  logic [31:0]   data_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [29:0]   req_word;
  logic [AW-1:0] req_idx;
  logic          req_fault;
  logic          accept;
  logic          load_resp;
  logic [AW-1:0] rd_idx;
  logic          rd_fault;

  // Fault flags are evaluated on the live address at acceptance time.
  assign req_word  = inst_mem_address[31:2];
  assign req_idx   = inst_mem_address[AW+1:2];
  assign req_fault = (|inst_mem_address[1:0]) || (req_word >= 30'(DEPTH_WORDS));

  // With wait states the read uses the latched request; with none it reads
  // straight from the request being accepted.
  assign rd_idx   = (state == S_WAIT) ? lat_idx   : req_idx;
  assign rd_fault = (state == S_WAIT) ? lat_fault : req_fault;

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    accept         = 1'b0;
    load_resp      = 1'b0;
    inst_mem_ready = 1'b0;
    inst_mem_is_valid = 1'b0;

    case (state)
      S_IDLE: begin
        inst_mem_ready = 1'b1;
        accept         = inst_mem_req;
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          load_resp = 1'b1;
          state_n   = S_RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP: begin
        inst_mem_is_valid = 1'b1;
        inst_mem_ready    = !stall;
        if (!stall) begin
          if (inst_mem_req) begin
            accept = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (accept) begin
      if (WAIT_STATES == 0) begin
        load_resp = 1'b1;
        state_n   = S_RESP;
      end else begin
        cnt_n   = 4'(WAIT_STATES - 1);
        state_n = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_fault <= 1'b0;
      data_q    <= NOP_WORD;
      err_q     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        lat_idx   <= req_idx;
        lat_fault <= req_fault;
      end
      // The array read sees the pre-write contents, so a same-cycle program
      // write to the fetched index returns the old word.
      if (load_resp) begin
        data_q <= rd_fault ? NOP_WORD : mem[rd_idx];
        err_q  <= rd_fault;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  assign inst_mem_read_data = data_q;
  assign inst_mem_err       = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder
module tb_imem_responder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic          stall = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_wdata = 32'h0;

  logic        ready0, valid0, err0;
  logic [31:0] data0;
  logic        ready3, valid3, err3;
  logic [31:0] data3;
  logic        ready5, valid5, err5;
  logic [31:0] data5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .inst_mem_req(req), .inst_mem_address(addr),
    .inst_mem_ready(ready0), .inst_mem_is_valid(valid0),
    .inst_mem_read_data(data0), .inst_mem_err(err0), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset), .inst_mem_req(req), .inst_mem_address(addr),
    .inst_mem_ready(ready3), .inst_mem_is_valid(valid3),
    .inst_mem_read_data(data3), .inst_mem_err(err3), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(5)) u_dut5 (
    .clk(clk), .reset(reset), .inst_mem_req(req), .inst_mem_address(addr),
    .inst_mem_ready(ready5), .inst_mem_is_valid(valid5),
    .inst_mem_read_data(data5), .inst_mem_err(err5), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic load(input int idx, input logic [31:0] w);
    prog_we    = 1'b1;
    prog_addr  = AW'(idx);
    prog_wdata = w;
    cyc();
    prog_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_valid;
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_data",  data0,       32'h0000_0013);
    chk("rst_err",   32'(err0),   32'd0);

    @(posedge clk); #1;
    load(0, 32'h0050_0093);
    load(1, 32'h00A0_0113);
    load(2, 32'h1234_5678);
    load(3, 32'h0000_A0B3);
    reset = 1'b1;

    // Back-to-back fetches, zero wait states
    req = 1'b1; addr = 32'h0; #1;
    chk("b2b_ready0", 32'(ready0), 32'd1);
    cyc();
    addr = 32'h4; #1;
    chk("b2b_valid0", 32'(valid0), 32'd1);
    chk("b2b_data0",  data0,       32'h0050_0093);
    chk("b2b_err0",   32'(err0),   32'd0);
    chk("b2b_ready1", 32'(ready0), 32'd1);
    cyc();
    req = 1'b0; #1;
    chk("b2b_valid1", 32'(valid0), 32'd1);
    chk("b2b_data1",  data0,       32'h00A0_0113);
    chk("b2b_err1",   32'(err0),   32'd0);
    cyc(); #1;
    chk("b2b_idle", 32'(valid0), 32'd0);

    // Three wait states
    rst();
    req = 1'b1; addr = 32'h8;
    cyc();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ws3_ready_c%0d", i), 32'(ready3), 32'd0);
      chk($sformatf("ws3_valid_c%0d", i), 32'(valid3), 32'd0);
      cyc();
    end
    #1;
    chk("ws3_valid", 32'(valid3), 32'd1);
    chk("ws3_data",  data3,       32'h1234_5678);
    chk("ws3_ready", 32'(ready3), 32'd1);
    cyc(); #1;
    chk("ws3_drop", 32'(valid3), 32'd0);

    // Faulting fetches
    rst();
    req = 1'b1; addr = 32'h2;
    cyc();
    addr = 32'h0000_1000; #1;
    chk("mis_valid", 32'(valid0), 32'd1);
    chk("mis_data",  data0,       32'h0000_0013);
    chk("mis_err",   32'(err0),   32'd1);
    cyc();
    req = 1'b0; #1;
    chk("oor_data", data0,       32'h0000_0013);
    chk("oor_err",  32'(err0),   32'd1);
    cyc();

    // Stall holds the response and blocks the next request
    rst();
    req = 1'b1; addr = 32'h0;
    cyc();
    stall = 1'b1; addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stl_valid_c%0d", i), 32'(valid0), 32'd1);
      chk($sformatf("stl_data_c%0d", i),  data0,       32'h0050_0093);
      chk($sformatf("stl_ready_c%0d", i), 32'(ready0), 32'd0);
      cyc();
    end
    stall = 1'b0; #1;
    chk("stl_rel_ready", 32'(ready0), 32'd1);
    chk("stl_rel_data",  data0,       32'h0050_0093);
    cyc();
    req = 1'b0; #1;
    chk("stl_next_data",  data0,       32'h00A0_0113);
    chk("stl_next_valid", 32'(valid0), 32'd1);
    cyc();

    // Reset mid-wait with five wait states
    rst();
    req = 1'b1; addr = 32'h4;
    cyc();
    req = 1'b0;
    cyc(); cyc(); #1;
    chk("rw_ready_wait", 32'(ready5), 32'd0);
    reset = 1'b0; #1;
    chk("rw_ready", 32'(ready5), 32'd1);
    chk("rw_data",  data5,       32'h0000_0013);
    chk("rw_valid", 32'(valid5), 32'd0);
    cyc();
    reset = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (valid5) saw_valid = 1'b1;
      cyc();
    end
    chk("rw_no_valid", 32'(saw_valid), 32'd0);

    // Program write colliding with the data load
    rst();
    req = 1'b1; addr = 32'hC;
    prog_we = 1'b1; prog_addr = AW'(3); prog_wdata = 32'hDEAD_BEEF;
    cyc();
    prog_we = 1'b0; req = 1'b0; #1;
    chk("col_old", data0, 32'h0000_A0B3);
    cyc();
    req = 1'b1; addr = 32'hC;
    cyc();
    req = 1'b0; #1;
    chk("col_new", data0, 32'hDEAD_BEEF);
    chk("col_err", 32'(err0), 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the pipelined RV32I core: the memory-side end of the fetch interface whose consumer is the fetch/decode stage. It accepts word-aligned fetch requests, waits a parameterised number of wait states, then returns `inst_mem_read_data` qualified by `inst_mem_is_valid`, holding the response while the pipeline stalls. A byte-free program-load port fills the array before or between runs.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit instruction words; power of two, ≥ 2.
- `WAIT_STATES`, 0: extra cycles between request acceptance and response; 0..15.
- `NOP_WORD`, 32'h0000_0013: word returned on reset and on faulting fetches (`addi x0,x0,0`).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `inst_mem_req` in 1: fetch request; sampled together with `inst_mem_address` when `inst_mem_ready` is high.
- `inst_mem_address` in 32: byte address of the fetch.
- `inst_mem_ready` out 1: the responder can accept a request this cycle.
- `inst_mem_is_valid` out 1: `inst_mem_read_data` holds a completed fetch.
- `inst_mem_read_data` out 32: fetched instruction word.
- `inst_mem_err` out 1: the current response is faulting (misaligned or out of range); qualified by `inst_mem_is_valid`.
- `stall` in 1: consumer stall; while high, a valid response is held.
- `prog_we` in 1: program-load write strobe.
- `prog_addr` in log2(DEPTH_WORDS): word index for the load.
- `prog_wdata` in 32: word to write.

## Operation
- Storage: `DEPTH_WORDS` x 32 register array. Word index = `inst_mem_address[AW+1:2]`, where AW = log2(DEPTH_WORDS). Array contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
  - IDLE: `ready`=1. On `req`, latch the address and the fault flags. Go to WAIT if `WAIT_STATES`>0 (counter loads `WAIT_STATES`-1); otherwise go to RESP with the data loaded.
  - WAIT: `ready`=0. The counter decrements. At 0, load the data/err registers and go to RESP.
  - RESP: `valid`=1. `ready` = !`stall`.
    - If `stall`: hold data, err, and valid unchanged.
    - Else if `req`: accept a new request as in IDLE (back-to-back).
    - Else: go to IDLE and drop valid.
- Fault detection, at acceptance:
  - misaligned = `address[1:0]` != 0.
  - out-of-range = `address[31:2]` ≥ `DEPTH_WORDS`.
  - On either fault: data = `NOP_WORD`, err = 1. The array is not read.
- Data sampling: the array is read in the cycle the response register is loaded.
  - A `prog_we` to the same index in that same cycle is not visible; the old word is returned.
- `prog_we`: writes `prog_wdata` at `prog_addr` in any state and any cycle. The write never stalls and never affects `ready`.
- `req` while `ready`=0 is ignored. The requester must hold the request until it sees `ready`.

## Timing
- Reset values: `inst_mem_ready`=1, `inst_mem_is_valid`=0, `inst_mem_read_data`=`NOP_WORD`, `inst_mem_err`=0. State is IDLE and the counter is 0.
- Latency: a request accepted at edge N gives `valid`=1 from cycle N+1+`WAIT_STATES`.
- Throughput:
  - `WAIT_STATES`=0 with `stall` low: one word per cycle.
  - Otherwise: one word per 1+`WAIT_STATES` cycles.
- Stall in RESP: valid, data, and err stay stable for every stalled cycle. The response is consumed on the first cycle with `stall` low.
- Stall during WAIT has no effect; the countdown continues.
- Reset asserted mid-WAIT or mid-RESP: the in-flight fetch is dropped and no valid pulse occurs afterwards. The outputs take their reset values asynchronously.
- After reset deasserts, the first request is accepted at the first rising edge with `req`=1.

## Test plan
- Load words 0x00500093, 0x00A00113 at indices 0 and 1. With `WAIT_STATES`=0, hold `req` with addresses 0x0 then 0x4 -> valid on consecutive cycles with those words, err=0, `ready` held at 1.
- `WAIT_STATES`=3, request address 0x8 -> `ready`=0 for 3 cycles, then valid for 1 cycle with word[2]. `ready` returns to 1 in the valid cycle.
- Request 0x2 (misaligned) -> data 0x00000013, err=1. Request 4*`DEPTH_WORDS` (out of range) -> same response, no array read.
- During RESP, hold `stall` high for 4 cycles with `req` high to a new address -> the first word stays stable and `ready`=0. The new request is accepted on the cycle `stall` drops.
- Assert `reset` during WAIT with `WAIT_STATES`=5 -> valid never rises for that fetch. Outputs go to `ready`=1, data=0x00000013 immediately.
- `prog_we` to index 3 with 0xDEADBEEF in the same cycle a fetch of 0xC loads data -> the old word is returned. A refetch of 0xC returns 0xDEADBEEF.
